// File: rtl/g_sensor_int_pkg.sv
// Shared definitions for the g-sensor INT1 conditioner.
//   gsi_state_t          : conditioner FSM states
//   CNT_W                : width of the filter (fcnt) and hold counters
//   FILTER_CYCLES_DEF    : default glitch-filter length, clk cycles
//   MIN_PULSE_CYCLES_DEF : default minimum int_clean high time, clk cycles
package g_sensor_int_pkg;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_QUAL_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_QUAL_LO = 2'd3
  } gsi_state_t;

  localparam int unsigned CNT_W                = 16;
  localparam int unsigned FILTER_CYCLES_DEF    = 16;
  localparam int unsigned MIN_PULSE_CYCLES_DEF = 8;

endpackage

// File: rtl/gsi_sync.sv
// Reset-to-0 synchroniser chain for the asynchronous INT1 pin.
//   STAGES : chain depth (2..4)
// Ports:
//   clk   : system clock
//   reset : asynchronous reset, active-high; clears every stage
//   d     : asynchronous input
//   q     : synchronised output (last stage)
module gsi_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_ff <= '0;
    else       sync_ff <= {sync_ff[STAGES-2:0], d};
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/g_sensor_int_conditioner.sv
// Conditions the raw ADXL345 INT1 pin for the g-sensor interrupt PIO in_port:
// synchronise, normalise polarity, reject short glitches, stretch accepted
// events to a minimum width, and count accepted events / rejected glitches.
// Build option: define GSI_GLITCH_CNT_EN to build the saturating glitch
// counter; otherwise glitch_count is tied to 0.
// Ports:
//   clk          : system clock
//   reset        : asynchronous reset, active-high
//   int_raw      : raw INT1 pin (asynchronous)
//   polarity     : 1 = pin active-high, 0 = pin active-low (quasi-static)
//   enable       : 0 = hold the conditioner idle
//   int_clean    : filtered active-high level for the PIO
//   rise_pulse   : one-cycle strobe per newly accepted event
//   event_count  : accepted events, wraps
//   glitch_count : rejected pulses, saturating (0 when not built)
module g_sensor_int_conditioner
  import g_sensor_int_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned FILTER_CYCLES    = FILTER_CYCLES_DEF,
  parameter int unsigned MIN_PULSE_CYCLES = MIN_PULSE_CYCLES_DEF,
  parameter int unsigned COUNT_W          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               int_raw,
  input  logic               polarity,
  input  logic               enable,
  output logic               int_clean,
  output logic               rise_pulse,
  output logic [COUNT_W-1:0] event_count,
  output logic [COUNT_W-1:0] glitch_count
);

  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(MIN_PULSE_CYCLES - 1);
  localparam logic [2:0]       WARM_LAST = 3'(SYNC_STAGES);

  logic             sync_out;
  logic             pin_active;
  logic [2:0]       warm;
  logic             warm_done;
  gsi_state_t       state, state_nx;
  logic [CNT_W-1:0] fcnt, fcnt_nx;
  logic [CNT_W-1:0] hold, hold_nx;
  logic             accept;
  logic             clean_nx;

  gsi_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (int_raw),
    .q     (sync_out)
  );

  // 1 = pin active, whatever its electrical polarity
  assign pin_active = sync_out ~^ polarity;

  // Keep the FSM in S_LOW while the reset values flush out of the sync chain
  assign warm_done = (warm == WARM_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           warm <= '0;
    else if (!warm_done) warm <= warm + 3'd1;
  end

  // State register; int_clean and rise_pulse are registered alongside it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_LOW;
      fcnt       <= '0;
      hold       <= '0;
      int_clean  <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      fcnt       <= fcnt_nx;
      hold       <= hold_nx;
      int_clean  <= clean_nx;
      rise_pulse <= accept;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    hold_nx  = hold;
    accept   = 1'b0;
    if (!enable || !warm_done) begin
      state_nx = S_LOW;
      fcnt_nx  = '0;
      hold_nx  = '0;
    end else begin
      case (state)
        S_LOW: begin
          if (pin_active) begin
            state_nx = S_QUAL_HI;
            fcnt_nx  = CNT_W'(1);
          end
        end
        S_QUAL_HI: begin
          if (!pin_active) begin
            state_nx = S_LOW;
          end else if (fcnt == FILT_LAST) begin
            state_nx = S_HIGH;
            hold_nx  = HOLD_INIT;
            accept   = 1'b1;
          end else begin
            fcnt_nx = fcnt + CNT_W'(1);
          end
        end
        S_HIGH: begin
          // Release is only considered once the minimum-width hold has run out
          if (hold != '0) begin
            hold_nx = hold - CNT_W'(1);
          end else if (!pin_active) begin
            state_nx = S_QUAL_LO;
            fcnt_nx  = CNT_W'(1);
          end
        end
        S_QUAL_LO: begin
          if (pin_active) begin
            state_nx = S_HIGH;
          end else if (fcnt == FILT_LAST) begin
            state_nx = S_LOW;
          end else begin
            fcnt_nx = fcnt + CNT_W'(1);
          end
        end
        default: begin
          state_nx = S_LOW;
        end
      endcase
    end
  end

  // Output decode of the next state, so int_clean leaves a flop
  always_comb begin
    clean_nx = (state_nx == S_HIGH) || (state_nx == S_QUAL_LO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       event_count <= '0;
    else if (accept) event_count <= event_count + COUNT_W'(1);
  end

`ifdef GSI_GLITCH_CNT_EN
  logic abort;

  assign abort = enable && warm_done && (state == S_QUAL_HI) && !pin_active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      glitch_count <= '0;
    else if (abort && (glitch_count != '1))
      glitch_count <= glitch_count + COUNT_W'(1);
  end
`else
  assign glitch_count = '0;
`endif

endmodule

// File: tb/tb_g_sensor_int_conditioner.sv
// Scoreboard bench for g_sensor_int_conditioner (FILTER_CYCLES=16,
// MIN_PULSE_CYCLES=8, SYNC_STAGES=2). A second instance with COUNT_W=4
// shares the stimulus to exercise event_count wrap.
module tb_g_sensor_int_conditioner;

  localparam int unsigned LAT = 18;
`ifdef GSI_GLITCH_CNT_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        int_raw = 1'b0;
  logic        polarity = 1'b1;
  logic        enable = 1'b1;
  logic        int_clean, rise_pulse;
  logic [15:0] event_count, glitch_count;
  logic        int_clean_w4, rise_pulse_w4;
  logic [3:0]  event_count_w4, glitch_count_w4;

  g_sensor_int_conditioner #(
    .SYNC_STAGES(2), .FILTER_CYCLES(16), .MIN_PULSE_CYCLES(8), .COUNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .int_raw(int_raw), .polarity(polarity),
    .enable(enable), .int_clean(int_clean), .rise_pulse(rise_pulse),
    .event_count(event_count), .glitch_count(glitch_count)
  );

  g_sensor_int_conditioner #(
    .SYNC_STAGES(2), .FILTER_CYCLES(16), .MIN_PULSE_CYCLES(8), .COUNT_W(4)
  ) dut_w4 (
    .clk(clk), .reset(reset), .int_raw(int_raw), .polarity(polarity),
    .enable(enable), .int_clean(int_clean_w4), .rise_pulse(rise_pulse_w4),
    .event_count(event_count_w4), .glitch_count(glitch_count_w4)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          rise;
    int unsigned cyc;
    int unsigned cnt;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned exp_evt = 0;
  int unsigned exp_glitch = 0;
  logic        clean_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_rise(input int unsigned at);
    exp_t e;
    exp_evt++;
    e.rise = 1'b1;
    e.cyc  = at;
    e.cnt  = exp_evt;
    sb.push_back(e);
  endtask

  task automatic push_fall(input int unsigned at);
    exp_t e;
    e.rise = 1'b0;
    e.cyc  = at;
    e.cnt  = exp_evt;
    sb.push_back(e);
  endtask

  // Bounded wait for all expected edges to be consumed
  task automatic settle(input int unsigned max_cyc);
    for (int unsigned i = 0; i < max_cyc && sb.size() != 0; i++) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    wait_cyc(5);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (int_clean !== clean_q) begin
      if (sb.size() == 0) begin
        check("unexpected_edge", {31'd0, int_clean}, {31'd0, clean_q});
      end else begin
        e = sb.pop_front();
        check(int_clean ? "rise_kind" : "fall_kind", {31'd0, int_clean}, {31'd0, e.rise});
        check(int_clean ? "rise_cycle" : "fall_cycle", cyc, e.cyc);
        if (int_clean) begin
          check("rise_pulse", {31'd0, rise_pulse}, 1);
          check("rise_pulse_w4", {31'd0, rise_pulse_w4}, 1);
          check("event_count", {16'd0, event_count}, e.cnt & 32'hffff);
          check("event_count_w4", {28'd0, event_count_w4}, e.cnt & 32'hf);
        end
      end
    end else if (rise_pulse !== 1'b0) begin
      check("rise_pulse_extra", {31'd0, rise_pulse}, 0);
    end
    clean_q = int_clean;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got cycle %0d, want finish", cyc);
    $fatal(1);
  end

  initial begin
    wait_cyc(3);
    check("rst_int_clean", {31'd0, int_clean}, 0);
    check("rst_rise_pulse", {31'd0, rise_pulse}, 0);
    check("rst_event_count", {16'd0, event_count}, 0);
    check("rst_glitch_count", {16'd0, glitch_count}, 0);
    check("rst_int_clean_w4", {31'd0, int_clean_w4}, 0);
    reset = 1'b0;
    wait_cyc(5);

    // Clean 40-cycle pulse
    push_rise(cyc + LAT);
    int_raw = 1'b1;
    wait_cyc(40);
    push_fall(cyc + LAT);
    int_raw = 1'b0;
    settle(60);
    check("clean_event_count", {16'd0, event_count}, exp_evt);

    // 10-cycle glitch is rejected
    int_raw = 1'b1;
    wait_cyc(10);
    int_raw = 1'b0;
    if (GLITCH_EN) exp_glitch++;
    wait_cyc(40);
    check("glitch_event_count", {16'd0, event_count}, exp_evt);
    check("glitch_count", {16'd0, glitch_count}, exp_glitch);
    check("glitch_count_w4", {28'd0, glitch_count_w4}, exp_glitch & 32'hf);

    // 5-cycle dropout inside an event stays one pulse
    push_rise(cyc + LAT);
    int_raw = 1'b1;
    wait_cyc(40);
    int_raw = 1'b0;
    wait_cyc(5);
    int_raw = 1'b1;
    wait_cyc(40);
    push_fall(cyc + LAT);
    int_raw = 1'b0;
    settle(60);
    check("dropout_event_count", {16'd0, event_count}, exp_evt);

    // Enable gating during S_HIGH, then re-enable with pin held active
    push_rise(cyc + LAT);
    int_raw = 1'b1;
    wait_cyc(30);
    push_fall(cyc + 1);
    enable = 1'b0;
    wait_cyc(5);
    push_rise(cyc + 16);
    enable = 1'b1;
    wait_cyc(30);
    push_fall(cyc + LAT);
    int_raw = 1'b0;
    settle(60);
    check("enable_event_count", {16'd0, event_count}, exp_evt);

    // Active-low pin idling at 1 through reset: no spurious event
    reset = 1'b1;
    polarity = 1'b0;
    int_raw = 1'b1;
    exp_evt = 0;
    exp_glitch = 0;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(30);
    check("al_no_spurious", {16'd0, event_count}, exp_evt);
    check("al_glitch_count", {16'd0, glitch_count}, exp_glitch);
    push_rise(cyc + LAT);
    int_raw = 1'b0;
    wait_cyc(30);
    push_fall(cyc + LAT);
    int_raw = 1'b1;
    settle(60);
    check("al_event_count", {16'd0, event_count}, exp_evt);

    // 17 events: the 4-bit counter wraps to 1
    reset = 1'b1;
    polarity = 1'b1;
    int_raw = 1'b0;
    exp_evt = 0;
    exp_glitch = 0;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(5);
    for (int i = 0; i < 17; i++) begin
      push_rise(cyc + LAT);
      int_raw = 1'b1;
      wait_cyc(40);
      push_fall(cyc + LAT);
      int_raw = 1'b0;
      wait_cyc(40);
    end
    settle(60);
    check("wrap_event_count", {16'd0, event_count}, exp_evt);
    check("wrap_event_count_w4", {28'd0, event_count_w4}, exp_evt & 32'hf);

    // Asynchronous reset in the middle of S_HIGH
    push_rise(cyc + LAT);
    int_raw = 1'b1;
    wait_cyc(25);
    @(posedge clk);
    #2;
    reset = 1'b1;
    int_raw = 1'b0;
    push_fall(cyc);
    exp_evt = 0;
    exp_glitch = 0;
    #1;
    check("midrst_int_clean", {31'd0, int_clean}, 0);
    check("midrst_event_count", {16'd0, event_count}, exp_evt);
    check("midrst_glitch_count", {16'd0, glitch_count}, exp_glitch);
    check("midrst_event_count_w4", {28'd0, event_count_w4}, exp_evt);
    @(negedge clk);
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(40);
    check("post_rst_event_count", {16'd0, event_count}, exp_evt);
    settle(10);

    check("sb_final", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
